// File: rtl/pll_lock_pkg.sv
// Shared types and constants for the PLL lock sequencer.
// Build option: PLL_LOCK_LOSS_CNT_EN adds the lock-loss event counter.
package pll_lock_pkg;

    typedef enum logic [1:0] {
        PLLRST    = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam int EVT_CNT_W = 8;

    // Event counters stick at all-ones rather than wrapping.
    function automatic logic [EVT_CNT_W-1:0] sat_inc(input logic [EVT_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/lock_sync2.sv
// Two-flop synchroniser bringing the asynchronous PLL lock into the CLKI domain.
module lock_sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // meta feeds q directly; nothing may be placed between the two flops.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// PLL reset sequencer and lock supervisor; releases SYS_RST after stable lock.
// Build option: define PLL_LOCK_LOSS_CNT_EN to add the LOSSES port and counter.
module pll_lock_sequencer
    import pll_lock_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = 10,
    parameter int LOCK_TIMEOUT_CYCLES = 10000,
    parameter int STABLE_CYCLES       = 1000
) (
    input  logic                 CLKI,
    input  logic                 RST,
    input  logic                 LOCK,
    output logic                 PLL_RST,
    output logic                 SYS_RST,
    output logic                 READY,
    output logic [EVT_CNT_W-1:0] RETRIES,
`ifdef PLL_LOCK_LOSS_CNT_EN
    output logic [EVT_CNT_W-1:0] LOSSES,
`endif
    output state_t               STATE
);

    localparam int RST_W = $clog2(PLL_RST_CYCLES) + 1;
    localparam int TO_W  = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
    localparam int STB_W = $clog2(STABLE_CYCLES) + 1;

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(PLL_RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);

    state_t           state, state_n;
    logic [RST_W-1:0] rst_cnt, rst_cnt_n;
    logic [TO_W-1:0]  to_cnt, to_cnt_n;
    logic [STB_W-1:0] stb_cnt, stb_cnt_n;
    logic             retry_inc;
    logic             lock_s;
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic             loss_inc;
`endif

    lock_sync2 u_lock_sync (
        .clk (CLKI),
        .rst (RST),
        .d   (LOCK),
        .q   (lock_s)
    );

    assign STATE = state;

    // Each counter is only non-zero inside its own state, so defaulting to
    // zero clears it on entry to that state.
    always_comb begin
        state_n   = state;
        rst_cnt_n = '0;
        to_cnt_n  = '0;
        stb_cnt_n = '0;
        retry_inc = 1'b0;
`ifdef PLL_LOCK_LOSS_CNT_EN
        loss_inc  = 1'b0;
`endif
        case (state)
            PLLRST: begin
                if (rst_cnt == RST_LAST) state_n = WAIT_LOCK;
                else                     rst_cnt_n = rst_cnt + 1'b1;
            end
            WAIT_LOCK: begin
                // Lock takes priority over a timeout landing on the same edge.
                if (lock_s) begin
                    state_n = STABLE;
                end else if (to_cnt == TO_LAST) begin
                    state_n   = PLLRST;
                    retry_inc = 1'b1;
                end else begin
                    to_cnt_n = to_cnt + 1'b1;
                end
            end
            STABLE: begin
                if (!lock_s)                state_n = WAIT_LOCK;
                else if (stb_cnt == STB_LAST) state_n = RUN;
                else                        stb_cnt_n = stb_cnt + 1'b1;
            end
            RUN: begin
                if (!lock_s) begin
                    state_n = WAIT_LOCK;
`ifdef PLL_LOCK_LOSS_CNT_EN
                    loss_inc = 1'b1;
`endif
                end
            end
            default: state_n = PLLRST;
        endcase
    end

    // Outputs are decoded from the next state so they change on the same edge as STATE.
    always_ff @(posedge CLKI) begin
        if (RST) begin
            state   <= PLLRST;
            rst_cnt <= '0;
            to_cnt  <= '0;
            stb_cnt <= '0;
            PLL_RST <= 1'b1;
            SYS_RST <= 1'b1;
            READY   <= 1'b0;
            RETRIES <= '0;
        end else begin
            state   <= state_n;
            rst_cnt <= rst_cnt_n;
            to_cnt  <= to_cnt_n;
            stb_cnt <= stb_cnt_n;
            PLL_RST <= (state_n == PLLRST);
            SYS_RST <= (state_n != RUN);
            READY   <= (state_n == RUN);
            if (retry_inc) RETRIES <= sat_inc(RETRIES);
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    always_ff @(posedge CLKI) begin
        if (RST)           LOSSES <= '0;
        else if (loss_inc) LOSSES <= sat_inc(LOSSES);
    end
`endif

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed and randomized checks of pll_lock_sequencer against an elapsed-time phase model.
// Build option: PLL_LOCK_LOSS_CNT_EN also connects and checks LOSSES.
module tb_pll_lock_sequencer;
    import pll_lock_pkg::*;

    localparam int P_RST = 4;
    localparam int P_TO  = 20;
    localparam int P_STB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       lock = 1'b0;
    logic       pll_rst, sys_rst, ready;
    logic [7:0] retries;
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0] losses;
`endif
    state_t     state;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_TIMEOUT_CYCLES (P_TO),
        .STABLE_CYCLES       (P_STB)
    ) dut (
        .CLKI    (clk),
        .RST     (rst),
        .LOCK    (lock),
        .PLL_RST (pll_rst),
        .SYS_RST (sys_rst),
        .READY   (ready),
        .RETRIES (retries),
`ifdef PLL_LOCK_LOSS_CNT_EN
        .LOSSES  (losses),
`endif
        .STATE   (state)
    );

    // Reference model: phase plus number of edges spent in it; LOCK is seen
    // by the phase logic two edges after it is sampled.
    localparam int PH_PLL = 10, PH_WAIT = 11, PH_STB = 12, PH_RUN = 13;
    int m_phase = PH_PLL;
    int m_since = 0;
    int m_retries = 0;
    int m_losses = 0;
    bit s1 = 1'b0, s2 = 1'b0, ls;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = PH_PLL; m_since = 0; m_retries = 0; m_losses = 0;
            s1 = 1'b0; s2 = 1'b0;
        end else begin
            ls = s2; s2 = s1; s1 = lock;
            m_since++;
            case (m_phase)
                PH_PLL: if (m_since >= P_RST) begin m_phase = PH_WAIT; m_since = 0; end
                PH_WAIT: begin
                    if (ls) begin
                        m_phase = PH_STB; m_since = 0;
                    end else if (m_since >= P_TO) begin
                        m_phase = PH_PLL; m_since = 0;
                        if (m_retries < 255) m_retries++;
                    end
                end
                PH_STB: begin
                    if (!ls) begin m_phase = PH_WAIT; m_since = 0; end
                    else if (m_since >= P_STB) begin m_phase = PH_RUN; m_since = 0; end
                end
                default: begin
                    if (!ls) begin
                        m_phase = PH_WAIT; m_since = 0;
                        if (m_losses < 255) m_losses++;
                    end
                end
            endcase
        end
    end

    function automatic state_t model_state();
        case (m_phase)
            PH_PLL:  return PLLRST;
            PH_WAIT: return WAIT_LOCK;
            PH_STB:  return STABLE;
            default: return RUN;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_check();
        chk("m_pll_rst", 32'(pll_rst), 32'(m_phase == PH_PLL));
        chk("m_sys_rst", 32'(sys_rst), 32'(m_phase != PH_RUN));
        chk("m_ready",   32'(ready),   32'(m_phase == PH_RUN));
        chk("m_retries", 32'(retries), 32'(m_retries));
        chk("m_state",   32'(state),   32'(model_state()));
`ifdef PLL_LOCK_LOSS_CNT_EN
        chk("m_losses",  32'(losses),  32'(m_losses));
`endif
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
        model_check();
    endtask

    task automatic run_to(input int c);
        while (cyc < c) tick();
    endtask

    // Leaves RST low at cycle 0, the cycle after the last reset edge.
    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        chk("rst_pll_rst", 32'(pll_rst), 32'd1);
        chk("rst_sys_rst", 32'(sys_rst), 32'd1);
        chk("rst_ready",   32'(ready),   32'd0);
        chk("rst_retries", 32'(retries), 32'd0);
        chk("rst_state",   32'(state),   32'(PLLRST));
`ifdef PLL_LOCK_LOSS_CNT_EN
        chk("rst_losses",  32'(losses),  32'd0);
`endif
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // Reset, PLL reset pulse width, then lock at cycle 10 releases at 21.
        lock = 1'b0;
        do_reset();
        for (int k = 1; k <= 3; k++) begin
            tick();
            chk("pll_pulse_hi", 32'(pll_rst), 32'd1);
        end
        tick();
        chk("pll_pulse_lo", 32'(pll_rst), 32'd0);
        run_to(10);
        lock = 1'b1;
        run_to(20);
        chk("rel_sys_rst_20", 32'(sys_rst), 32'd1);
        run_to(21);
        chk("rel_sys_rst_21", 32'(sys_rst), 32'd0);
        chk("rel_ready_21",   32'(ready),   32'd1);

        // Lock loss in RUN, then restore without a PLL reset.
        run_to(30);
        lock = 1'b0;
        run_to(32);
        chk("loss_ready_32", 32'(ready), 32'd1);
        run_to(33);
        chk("loss_ready_33",   32'(ready),   32'd0);
        chk("loss_sys_rst_33", 32'(sys_rst), 32'd1);
`ifdef PLL_LOCK_LOSS_CNT_EN
        chk("loss_count", 32'(losses), 32'd1);
`endif
        lock = 1'b1;
        while (cyc < 44) begin
            tick();
            chk("loss_no_pll_rst", 32'(pll_rst), 32'd0);
            if (cyc == 43) chk("rerel_sys_rst_43", 32'(sys_rst), 32'd1);
        end
        chk("rerel_sys_rst_44", 32'(sys_rst), 32'd0);

        // Reset during RUN.
        run_to(50);
        rst = 1'b1;
        tick();
        chk("rrun_pll_rst", 32'(pll_rst), 32'd1);
        chk("rrun_sys_rst", 32'(sys_rst), 32'd1);
        chk("rrun_ready",   32'(ready),   32'd0);

        // Timeout retries every 24 cycles, then reset during STABLE.
        lock = 1'b0;
        do_reset();
        run_to(23);
        chk("to_retries_23", 32'(retries), 32'd0);
        run_to(24);
        chk("to_retries_24", 32'(retries), 32'd1);
        chk("to_pll_rst_24", 32'(pll_rst), 32'd1);
        run_to(48);
        chk("to_retries_48", 32'(retries), 32'd2);
        run_to(72);
        chk("to_retries_72", 32'(retries), 32'd3);
        run_to(80);
        lock = 1'b1;
        run_to(86);
        chk("rstb_state", 32'(state), 32'(STABLE));
        rst = 1'b1;
        tick();
        chk("rstb_pll_rst", 32'(pll_rst), 32'd1);
        chk("rstb_sys_rst", 32'(sys_rst), 32'd1);
        chk("rstb_retries", 32'(retries), 32'd0);

        // Unstable lock: high 5, low 1, high again; release 11 after final rise.
        lock = 1'b0;
        do_reset();
        run_to(10);
        lock = 1'b1;
        run_to(15);
        lock = 1'b0;
        run_to(16);
        lock = 1'b1;
        run_to(26);
        chk("unst_sys_rst_26", 32'(sys_rst), 32'd1);
        run_to(27);
        chk("unst_sys_rst_27", 32'(sys_rst), 32'd0);

        // lock_s rises on the timeout edge: lock wins, no retry counted.
        lock = 1'b0;
        do_reset();
        run_to(21);
        lock = 1'b1;
        run_to(23);
        chk("sim_state_23", 32'(state), 32'(WAIT_LOCK));
        run_to(24);
        chk("sim_state_24",   32'(state),   32'(STABLE));
        chk("sim_retries_24", 32'(retries), 32'd0);
        chk("sim_pll_rst_24", 32'(pll_rst), 32'd0);

        // RETRIES saturation.
        lock = 1'b0;
        do_reset();
        run_to(24 * 254 + 23);
        chk("sat_retries_254", 32'(retries), 32'd254);
        run_to(24 * 255);
        chk("sat_retries_255", 32'(retries), 32'd255);
        run_to(24 * 258);
        chk("sat_retries_hold", 32'(retries), 32'd255);

        // Randomized lock activity with occasional resets, checked by the model.
        do_reset();
        while (cyc < 3000) begin
            int len;
            len  = $urandom_range(1, 30);
            lock = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) < 3) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
            end
            repeat (len) tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
